prog_chain_loader: RTL and testbench

Drives the serial configuration chain formed by the programmable routing blocks (prog_in → prog_out daisy chain, prog_en-gated shifting). It accepts configuration words over a valid/ready port, serializes them onto the chain head, and counts exactly CHAIN_LEN bits. While loading, it captures the bits leaving the chain tail and returns them as words, so the previous configuration is read back during every load.

---
 rtl/prog_pkg.sv | 19 +
 rtl/prog_rb_packer.sv | 57 +++++
 rtl/prog_chain_loader.sv | 126 ++++++++++++
 tb/tb_prog_chain_loader.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_pkg.sv
// Shared state encoding and chain-length helper for the configuration-chain loader.
package prog_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } prog_state_t;

    localparam int unsigned MUXES_PER_TRACK = 4;
    localparam int unsigned BITS_PER_MUX    = 2;

    // One routing block of WIDTH tracks contributes WIDTH*4 muxes of 2 bits each.
    function automatic int unsigned block_chain_len(input int unsigned width);
        return width * MUXES_PER_TRACK * BITS_PER_MUX;
    endfunction

endpackage

// File: rtl/prog_rb_packer.sv
// Serial-in, parallel-out collector for bits leaving the chain tail; strobes a word
// when full or when flushed on the final chain bit (upper bits zero-padded).
module prog_rb_packer #(
    parameter int WORD_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_shift,
    input  logic              i_flush,
    input  logic              i_bit,
    output logic [WORD_W-1:0] o_data,
    output logic              o_valid
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [IDX_W-1:0]  r_idx;
    logic [WORD_W-1:0] r_acc;
    logic [WORD_W-1:0] w_next;
    logic              w_emit;

    always_comb begin
        w_next        = r_acc;
        w_next[r_idx] = i_bit;
    end

    assign w_emit = i_shift && (i_flush || (r_idx == IDX_W'(WORD_W - 1)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx   <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            o_valid <= w_emit;
            if (w_emit) begin
                o_data <= w_next;
            end
            if (i_clr || w_emit) begin
                r_idx <= '0;
            end else if (i_shift) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Accumulator is cleared at load start, so it needs no reset of its own.
    always_ff @(posedge i_clk) begin
        if (i_clr || w_emit) begin
            r_acc <= '0;
        end else if (i_shift) begin
            r_acc <= w_next;
        end
    end

endmodule

// File: rtl/prog_chain_loader.sv
// Serializes configuration words onto the routing-block prog chain and returns the
// previous chain contents as readback words during the same load.
module prog_chain_loader
    import prog_pkg::*;
#(
    parameter int CHAIN_LEN = block_chain_len(3),
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              prog_data,
    output logic              prog_en,
    input  logic              chain_tail,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);

    localparam int IDX_W = $clog2(WORD_W + 1);

    prog_state_t       r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [WORD_W-1:0] r_sreg;

    logic w_in_shift;
    logic w_take;
    logic w_last_bit;
    logic w_word_end;
    logic w_clr;

    assign w_in_shift = (r_state == SHIFT);
    assign w_take     = (r_state == FETCH) && word_valid && word_ready;
    assign w_last_bit = (r_cnt == CNT_W'(CHAIN_LEN - 1));
    assign w_word_end = (r_idx == IDX_W'(WORD_W - 1));
    assign w_clr      = (r_state == IDLE) && start;

    always_ff @(posedge prog_clk or posedge prog_rst) begin
        if (prog_rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            word_ready <= 1'b0;
            prog_en    <= 1'b0;
            prog_data  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= FETCH;
                        r_cnt      <= '0;
                        busy       <= 1'b1;
                        word_ready <= 1'b1;
                    end
                end
                FETCH: begin
                    if (w_take) begin
                        r_state    <= SHIFT;
                        r_idx      <= '0;
                        word_ready <= 1'b0;
                        prog_en    <= 1'b1;
                        prog_data  <= word_data[0];
                    end
                end
                SHIFT: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_idx <= r_idx + 1'b1;
                    // The chain-length limit wins over the word boundary, which drops
                    // the unused upper bits of a short final word.
                    if (w_last_bit) begin
                        r_state   <= DONE;
                        prog_en   <= 1'b0;
                        prog_data <= 1'b0;
                        done      <= 1'b1;
                    end else if (w_word_end) begin
                        r_state    <= FETCH;
                        prog_en    <= 1'b0;
                        prog_data  <= 1'b0;
                        word_ready <= 1'b1;
                    end else begin
                        prog_data <= r_sreg[1];
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Word shift register: bit 1 is always the next bit to present on prog_data.
    always_ff @(posedge prog_clk) begin
        if (w_take) begin
            r_sreg <= word_data;
        end else if (w_in_shift) begin
            r_sreg <= r_sreg >> 1;
        end
    end

    prog_rb_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .i_clk   (prog_clk),
        .i_rst   (prog_rst),
        .i_clr   (w_clr),
        .i_shift (w_in_shift),
        .i_flush (w_in_shift && w_last_bit),
        .i_bit   (chain_tail),
        .o_data  (rb_data),
        .o_valid (rb_valid)
    );

endmodule

// File: tb/tb_prog_chain_loader.sv
// Bench for prog_chain_loader: default 24-bit chain and a 20-bit chain instance, each
// with a behavioural chain attached, checked against a queue-based load model.
module tb_prog_chain_loader;

    localparam int W  = 8;
    localparam int L0 = 24;
    localparam int L1 = 20;

    logic         prog_clk = 1'b0;
    logic         prog_rst;
    logic         start;
    logic         word_valid;
    logic [W-1:0] word_data;
    logic         sel;

    logic         start_a, busy_a, done_a, wr_a, pd_a, pe_a, tail_a, rbv_a;
    logic [W-1:0] rbd_a;
    logic         start_b, busy_b, done_b, wr_b, pd_b, pe_b, tail_b, rbv_b;
    logic [W-1:0] rbd_b;

    logic         busy, done, word_ready, prog_data, prog_en, rb_valid;
    logic [W-1:0] rb_data;

    logic [L0-1:0] chain_a = '0;
    logic [L1-1:0] chain_b = '0;

    logic model_a[$];
    logic model_b[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 prog_clk = ~prog_clk;

    assign start_a = start & ~sel;
    assign start_b = start & sel;

    assign busy       = sel ? busy_b : busy_a;
    assign done       = sel ? done_b : done_a;
    assign word_ready = sel ? wr_b   : wr_a;
    assign prog_data  = sel ? pd_b   : pd_a;
    assign prog_en    = sel ? pe_b   : pe_a;
    assign rb_valid   = sel ? rbv_b  : rbv_a;
    assign rb_data    = sel ? rbd_b  : rbd_a;

    always @(posedge prog_clk) begin
        if (pe_a) chain_a <= {chain_a[L0-2:0], pd_a};
        if (pe_b) chain_b <= {chain_b[L1-2:0], pd_b};
    end
    assign tail_a = chain_a[L0-1];
    assign tail_b = chain_b[L1-1];

    prog_chain_loader u_dut (
        .prog_clk   (prog_clk),
        .prog_rst   (prog_rst),
        .start      (start_a),
        .busy       (busy_a),
        .done       (done_a),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (wr_a),
        .prog_data  (pd_a),
        .prog_en    (pe_a),
        .chain_tail (tail_a),
        .rb_data    (rbd_a),
        .rb_valid   (rbv_a)
    );

    prog_chain_loader #(.CHAIN_LEN(L1), .WORD_W(W)) u_dut20 (
        .prog_clk   (prog_clk),
        .prog_rst   (prog_rst),
        .start      (start_b),
        .busy       (busy_b),
        .done       (done_b),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (wr_b),
        .prog_data  (pd_b),
        .prog_en    (pe_b),
        .chain_tail (tail_b),
        .rb_data    (rbd_b),
        .rb_valid   (rbv_b)
    );

    // Ideal chain: the oldest bit sits at the tail and leaves first.
    function automatic logic model_shift(input logic b);
        logic o;
        if (sel) begin
            o = model_b.pop_front();
            model_b.push_back(b);
        end else begin
            o = model_a.pop_front();
            model_a.push_back(b);
        end
        return o;
    endfunction

    task automatic run_load(input logic [W-1:0] w0, input logic [W-1:0] w1, input logic [W-1:0] w2,
                            input int stall_word, input int stall_len, input int pulse_c,
                            input bit start_in_done, input int abort_after, input string tag);
        logic [W-1:0] wv [3];
        logic         exp_bits[$];
        logic         got_bits[$];
        logic [W-1:0] exp_rb[$];
        logic [W-1:0] got_rb[$];
        int           exp_en[$];
        int           got_en[$];
        logic [31:0]  eb, gb, er, gr;
        logic [W-1:0] acc;
        int clen, nsh, k, stall_left, c, done_c, exp_done, cur, fc, n, nrb;
        int busy_err, ovl_err, en_err;
        bit rb_at_done, aborted, timed_out;

        wv[0] = w0; wv[1] = w1; wv[2] = w2;
        clen = sel ? L1 : L0;
        nsh  = (abort_after > 0) ? abort_after : clen;
        for (int i = 0; i < clen; i++) exp_bits.push_back(wv[i / W][i % W]);
        acc = '0;
        for (int i = 0; i < nsh; i++) begin
            acc[i % W] = model_shift(exp_bits[i]);
            if ((i % W == W - 1) || (i == clen - 1)) begin
                exp_rb.push_back(acc);
                acc = '0;
            end
        end
        cur = 1;
        for (int kk = 0; kk * W < clen; kk++) begin
            fc = cur + ((kk == stall_word) ? stall_len : 0);
            n  = (clen - kk * W < W) ? (clen - kk * W) : W;
            for (int j = 1; j <= n; j++) exp_en.push_back(fc + j);
            cur = fc + n + 1;
        end
        exp_done = cur;

        k = 0; stall_left = stall_len; done_c = -1;
        busy_err = 0; ovl_err = 0; en_err = 0;
        rb_at_done = 0; aborted = 0; timed_out = 0;

        @(negedge prog_clk);
        start = 1'b1; word_valid = 1'($urandom); word_data = W'($urandom);
        for (c = 1; c <= 200; c++) begin
            @(negedge prog_clk);
            start = 1'b0;
            if (busy !== 1'b1) busy_err++;
            if (prog_en) begin
                got_en.push_back(c);
                got_bits.push_back(prog_data);
                if (word_ready) ovl_err++;
            end
            if (rb_valid) got_rb.push_back(rb_data);
            if (abort_after > 0 && got_en.size() == abort_after + 1) begin
                aborted = 1;
                break;
            end
            if (done) begin
                done_c = c;
                rb_at_done = rb_valid;
                break;
            end
            start = (c == pulse_c);
            if (word_ready) begin
                if (k == stall_word && stall_left > 0) begin
                    word_valid = 1'b0;
                    word_data  = W'($urandom);
                    stall_left--;
                end else begin
                    word_valid = 1'b1;
                    word_data  = wv[k];
                    k++;
                end
            end else begin
                word_valid = 1'($urandom);
                word_data  = W'($urandom);
            end
        end
        if (!aborted && done_c < 0) timed_out = 1;

        n_checks++;
        if (timed_out) begin
            n_fail++;
            $display("FAIL %s timeout: no done within 200 cycles", tag);
            prog_rst = 1'b1; #1; prog_rst = 1'b0;
        end

        if (aborted) begin
            prog_rst = 1'b1; start = 1'b0; word_valid = 1'b0;
            #1;
            n_checks++;
            if ({busy, done, word_ready, prog_en, prog_data, rb_valid, rb_data} !== '0) begin
                n_fail++;
                $display("FAIL %s async_reset_outputs: got busy=%b done=%b rdy=%b en=%b pd=%b rbv=%b rbd=%h, want all 0",
                         tag, busy, done, word_ready, prog_en, prog_data, rb_valid, rb_data);
            end
            for (int i = 0; i < 3; i++) begin
                @(negedge prog_clk);
                n_checks++;
                if ({rb_valid, done} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL %s reset_hold: got rbv=%b done=%b want 0 0", tag, rb_valid, done);
                end
            end
            prog_rst = 1'b0;
            @(negedge prog_clk);
        end else if (!timed_out) begin
            n_checks++;
            if (done_c != exp_done) begin
                n_fail++;
                $display("FAIL %s done_cycle: got %0d want %0d", tag, done_c, exp_done);
            end
            n_checks++;
            if (rb_at_done !== 1'b1) begin
                n_fail++;
                $display("FAIL %s rb_with_done: got %b want 1", tag, rb_at_done);
            end
            start = start_in_done;
            word_valid = 1'($urandom);
            @(negedge prog_clk);
            start = 1'b0;
            word_valid = 1'b0;
            n_checks++;
            if ({busy, done, word_ready, prog_en} !== 4'b0000) begin
                n_fail++;
                $display("FAIL %s after_done: got busy=%b done=%b rdy=%b en=%b want 0 0 0 0",
                         tag, busy, done, word_ready, prog_en);
            end
        end

        n_checks++;
        if (got_en.size() != (aborted ? nsh + 1 : nsh)) begin
            n_fail++;
            $display("FAIL %s shift_count: got %0d want %0d", tag, got_en.size(), aborted ? nsh + 1 : nsh);
        end
        eb = '0; gb = '0;
        for (int i = 0; i < nsh; i++) begin
            eb[i] = exp_bits[i];
            gb[i] = (i < got_bits.size()) ? got_bits[i] : ~exp_bits[i];
            if (i >= got_en.size() || got_en[i] != exp_en[i]) en_err++;
        end
        n_checks++;
        if (gb !== eb) begin
            n_fail++;
            $display("FAIL %s prog_data_bits: got %h want %h", tag, gb, eb);
        end
        n_checks++;
        if (en_err != 0) begin
            n_fail++;
            $display("FAIL %s prog_en_cycles: got %0d misplaced want 0", tag, en_err);
        end
        n_checks++;
        if (got_rb.size() != exp_rb.size()) begin
            n_fail++;
            $display("FAIL %s rb_count: got %0d want %0d", tag, got_rb.size(), exp_rb.size());
        end
        er = '0; gr = '0;
        nrb = (got_rb.size() < exp_rb.size()) ? got_rb.size() : exp_rb.size();
        for (int i = 0; i < nrb && i < 4; i++) begin
            er[i*W +: W] = exp_rb[i];
            gr[i*W +: W] = got_rb[i];
        end
        n_checks++;
        if (gr !== er) begin
            n_fail++;
            $display("FAIL %s rb_words: got %h want %h", tag, gr, er);
        end
        n_checks++;
        if (busy_err != 0 || ovl_err != 0) begin
            n_fail++;
            $display("FAIL %s busy_and_overlap: got busy_low=%0d en_with_ready=%0d want 0 0", tag, busy_err, ovl_err);
        end
    endtask

    task automatic test_reset();
        prog_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom); word_valid = 1'($urandom); word_data = W'($urandom);
            @(negedge prog_clk);
            n_checks++;
            if ({busy_a, done_a, wr_a, pe_a, pd_a, rbv_a, rbd_a, busy_b, done_b, wr_b, pe_b, pd_b, rbv_b, rbd_b} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: got a=%b%b%b%b%b%b/%h b=%b%b%b%b%b%b/%h want all 0",
                         busy_a, done_a, wr_a, pe_a, pd_a, rbv_a, rbd_a, busy_b, done_b, wr_b, pe_b, pd_b, rbv_b, rbd_b);
            end
        end
        prog_rst = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            word_valid = 1'($urandom); word_data = W'($urandom);
            @(negedge prog_clk);
            n_checks++;
            if ({busy_a, done_a, wr_a, pe_a, rbv_a, busy_b, done_b, wr_b, pe_b, rbv_b} !== '0) begin
                n_fail++;
                $display("FAIL idle_no_activity: got a=%b%b%b%b%b b=%b%b%b%b%b want all 0",
                         busy_a, done_a, wr_a, pe_a, rbv_a, busy_b, done_b, wr_b, pe_b, rbv_b);
            end
        end
        word_valid = 1'b0;
    endtask

    task automatic test_defaults();
        sel = 1'b0;
        run_load(8'hA5, 8'h3C, 8'h0F, -1, 0, -1, 1'b0, 0, "defaults");
    endtask

    task automatic test_readback();
        sel = 1'b0;
        run_load(8'h11, 8'h22, 8'h33, -1, 0, -1, 1'b1, 0, "reload");
    endtask

    task automatic test_stall();
        sel = 1'b0;
        run_load(W'($urandom), W'($urandom), W'($urandom), 1, 5, 14, 1'b0, 0, "stall");
        run_load(W'($urandom), W'($urandom), W'($urandom), -1, 0, 5, 1'b0, 0, "after_stall");
    endtask

    task automatic test_chain20();
        sel = 1'b1;
        run_load(8'hFF, 8'hFF, 8'hFF, -1, 0, -1, 1'b0, 0, "c20_first");
        run_load(8'hFF, 8'hFF, 8'hFF, -1, 0, -1, 1'b0, 0, "c20_second");
    endtask

    task automatic test_reset_mid_shift();
        sel = 1'b0;
        run_load(W'($urandom), W'($urandom), W'($urandom), -1, 0, -1, 1'b0, 10, "abort");
        run_load(W'($urandom), W'($urandom), W'($urandom), -1, 0, -1, 1'b0, 0, "post_abort");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            sel = 1'($urandom);
            run_load(W'($urandom), W'($urandom), W'($urandom), $urandom_range(0, 2), $urandom_range(0, 6),
                     $urandom_range(2, 26), 1'($urandom), 0, "random");
        end
    endtask

    initial begin
        for (int i = 0; i < L0; i++) model_a.push_back(1'b0);
        for (int i = 0; i < L1; i++) model_b.push_back(1'b0);
        sel = 1'b0; start = 1'b0; word_valid = 1'b0; word_data = '0; prog_rst = 1'b1;
        test_reset();
        test_defaults();
        test_readback();
        test_stall();
        test_chain20();
        test_reset_mid_shift();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
